// File: rtl/audio_feed_pio_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED PIO: address/strobe/data in, combinational readdata out.
interface audio_feed_pio_led_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input readdata);
    modport slave  (input address, input chipselect, input write_n, input writedata,
                    output readdata);
endinterface

// File: rtl/audio_feed_pio_led_ctrl.sv
// Parametrised LED output PIO with atomic set/clear/toggle and a per-bit blink engine
// driven by a programmable half-period counter.
module audio_feed_pio_led_ctrl #(
    parameter int                    DATA_WIDTH   = 10,
    parameter int                    PERIOD_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    audio_feed_pio_led_ctrl_if.slave  bus,
    output logic [DATA_WIDTH-1:0]     out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;
    localparam logic [2:0] A_TGL    = 3'd6;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_blink_en;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic                    r_phase;

    logic                    w_wr;
    logic [DATA_WIDTH-1:0]   w_wd;
    logic [PERIOD_WIDTH-1:0] w_wp;
    logic                    w_period_wr;
    logic                    w_resync;
    logic                    w_term;
    logic                    w_unused;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wd        = bus.writedata[DATA_WIDTH-1:0];
    assign w_wp        = bus.writedata[PERIOD_WIDTH-1:0];
    assign w_period_wr = w_wr && (bus.address == A_PERIOD);
    assign w_resync    = w_wr && (bus.address == A_CTRL) && bus.writedata[0];
    assign w_term      = (r_cnt == r_period - PERIOD_WIDTH'(1));
    assign w_unused    = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
            r_period   <= '0;
        end else if (w_wr) begin
            case (bus.address)
                A_DATA:   r_data     <= w_wd;
                A_BLINK:  r_blink_en <= w_wd;
                A_PERIOD: r_period   <= w_wp;
                A_SET:    r_data     <= r_data | w_wd;
                A_CLR:    r_data     <= r_data & ~w_wd;
                A_TGL:    r_data     <= r_data ^ w_wd;
                default:  ;
            endcase
        end
    end

    // Register writes take priority over the terminal-count wrap; period 0 freezes phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_period_wr) begin
            r_cnt   <= '0;
        end else if (w_resync) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_period == '0) begin
            r_cnt   <= '0;
        end else if (w_term) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_port <= RESET_VALUE;
        else          out_port <= r_data & ~(r_blink_en & {DATA_WIDTH{~r_phase}});
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            A_DATA:   bus.readdata = 32'(r_data);
            A_BLINK:  bus.readdata = 32'(r_blink_en);
            A_PERIOD: bus.readdata = 32'(r_period);
            A_CTRL:   bus.readdata = {31'b0, r_phase};
            default:  bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_audio_feed_pio_led_ctrl.sv
// Scenario bench for the LED PIO: out_port expectations go through a scoreboard queue.
module tb_audio_feed_pio_led_ctrl;
    localparam int              DW  = 10;
    localparam logic [DW-1:0]   RST = 10'h155;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] out_port;
    int            n_cmp;
    int            n_err;
    logic [DW-1:0] exp_q[$];

    audio_feed_pio_led_ctrl_if bus_if();

    audio_feed_pio_led_ctrl #(.DATA_WIDTH(DW), .PERIOD_WIDTH(24), .RESET_VALUE(RST)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if), .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.address = a; bus_if.writedata = d;
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus_if.address = a; #1;
        d = bus_if.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        bus_if.address = 3'd0; bus_if.writedata = '0;
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        n_cmp++; if (out_port !== RST) begin n_err++; $display("FAIL rst_out got %h want %h", out_port, RST); end
        rd(3'd0, d);
        n_cmp++; if (d !== 32'(RST)) begin n_err++; $display("FAIL rst_data got %h want %h", d, RST); end
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL rst_status got %h want 1", d); end
        tick();
        rd(3'd1, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_blink got %h want 0", d); end
        rd(3'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_period got %h want 0", d); end
        tick();
    endtask

    task automatic test_atomic();
        logic [DW-1:0] v;
        logic [DW-1:0] got;
        logic [31:0]   d;
        v = 10'h0F0;          exp_q.push_back(v);
        v = v | 10'h003;      exp_q.push_back(v);
        v = v & ~10'h030;     exp_q.push_back(v);
        v = v ^ 10'h201;      exp_q.push_back(v);
        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h003);
        got = exp_q.pop_front();
        n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL atom_data got %h want %h", out_port, got); end
        wr(3'd5, 32'hFFFF_F030);
        got = exp_q.pop_front();
        n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL atom_set got %h want %h", out_port, got); end
        wr(3'd6, 32'h201);
        got = exp_q.pop_front();
        n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL atom_clr got %h want %h", out_port, got); end
        tick();
        got = exp_q.pop_front();
        n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL atom_tgl got %h want %h", out_port, got); end
        rd(3'd0, d);
        n_cmp++; if (d !== 32'h2C2) begin n_err++; $display("FAIL atom_rd got %h want 2c2", d); end
        tick();
        for (int a = 4; a <= 6; a++) begin
            rd(3'(a), d);
            n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rd_wo%0d got %h want 0", a, d); end
        end
        tick();
    endtask

    task automatic test_blink();
        logic [DW-1:0] got;
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h00F);
        wr(3'd2, 32'd4);
        wr(3'd3, 32'd1);
        for (int k = 1; k <= 16; k++)
            exp_q.push_back((((k - 1) / 4) % 2 == 0) ? 10'h3FF : 10'h3F0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            got = exp_q.pop_front();
            n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL blink4_c%0d got %h want %h", k, out_port, got); end
        end
    endtask

    task automatic test_period1_freeze();
        logic [DW-1:0] got;
        logic [31:0]   d;
        wr(3'd2, 32'd1);
        wr(3'd3, 32'd1);
        for (int k = 1; k <= 5; k++) exp_q.push_back((k % 2 == 1) ? 10'h3FF : 10'h3F0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = exp_q.pop_front();
            n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL blink1_c%0d got %h want %h", k, out_port, got); end
        end
        // Phase is 0 here; PERIOD=0 must freeze it rather than force it high
        wr(3'd2, 32'd0);
        repeat (4) exp_q.push_back(10'h3F0);
        for (int k = 0; k < 4; k++) begin
            got = exp_q.pop_front();
            n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL frz_c%0d got %h want %h", k, out_port, got); end
            tick();
        end
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL frz_status got %h want 0", d); end
        tick();
        wr(3'd3, 32'd1);
        exp_q.push_back(10'h3F0);
        repeat (3) exp_q.push_back(10'h3FF);
        for (int k = 0; k < 4; k++) begin
            got = exp_q.pop_front();
            n_cmp++; if (out_port !== got) begin n_err++; $display("FAIL resync_c%0d got %h want %h", k, out_port, got); end
            tick();
        end
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL resync_status got %h want 1", d); end
        tick();
    endtask

    task automatic test_period_at_terminal();
        logic [31:0] d;
        logic        want;
        wr(3'd2, 32'd5);
        wr(3'd3, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            rd(3'd3, d);
            n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL p5_status%0d got %h want 1", k, d); end
            tick();
        end
        wr(3'd2, 32'd3);
        for (int k = 0; k <= 3; k++) begin
            want = (k < 3);
            rd(3'd3, d);
            n_cmp++; if (d !== 32'(want)) begin n_err++; $display("FAIL p3_status%0d got %h want %h", k, d, want); end
            if (k < 3) tick();
        end
        rd(3'd2, d);
        n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL p3_rd got %h want 3", d); end
        tick();
    endtask

    task automatic test_async_reset_and_ignored();
        logic [31:0] d;
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (out_port !== RST) begin n_err++; $display("FAIL arst_out got %h want %h", out_port, RST); end
        @(negedge clk);
        rd(3'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL arst_period got %h want 0", d); end
        reset_n = 1'b1;
        tick();
        bus_if.address = 3'd0; bus_if.writedata = 32'h0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b0;
        tick();
        bus_if.write_n = 1'b1;
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0, d);
        n_cmp++; if (d !== 32'(RST)) begin n_err++; $display("FAIL ign_data got %h want %h", d, RST); end
        rd(3'd1, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL ign_blink got %h want 0", d); end
        tick();
        rd(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL ign_status got %h want 1", d); end
        rd(3'd7, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL ign_rd7 got %h want 0", d); end
        n_cmp++; if (out_port !== RST) begin n_err++; $display("FAIL ign_out got %h want %h", out_port, RST); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_atomic();
        test_blink();
        test_period1_freeze();
        test_period_at_terminal();
        test_async_reset_and_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
